seq_match_sched: RTL and testbench

Shared-engine overlapping serial pattern detector for N_CH independent bit-serial channels. A round-robin scheduler grants one requester per cycle to a single match engine; per-channel match context (bit history + fill count) is saved in a context register file. The block replaces per-channel detector instances wherever several low-rate serial streams need the same pattern watched. The pattern is runtime-programmable, and each channel keeps a saturating match counter.

---
 rtl/seq_match_sched.sv | 81 ++++++++
 tb/tb_seq_match_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seq_match_sched.sv
// seq_match_sched: one match engine shared round-robin by N_CH serial channels, with per-channel context and saturating match counters
module seq_match_sched #(
  parameter int N_CH = 4,
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [PAT_W-1:0]      cfg_pattern,
  input  logic                  cnt_clr,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       data,
  output logic [N_CH-1:0]       gnt,
  output logic [N_CH-1:0]       flag,
  output logic [N_CH*CNT_W-1:0] match_cnt
);
  localparam int PW = $clog2(N_CH);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-1:0] hist_q [N_CH];
  logic [FW-1:0] fill_q [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [PW-1:0] ptr_q;
  logic [N_CH-1:0] flag_q;
  logic [PW-1:0] k;
  logic any;
  logic [PAT_W-1:0] hist_d;
  logic [FW-1:0] fill_d;
  logic hit;
  always_comb begin
    int j;
    k = '0;
    any = 1'b0;
    j = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = (int'(ptr_q) + i >= N_CH) ? int'(ptr_q) + i - N_CH : int'(ptr_q) + i;
      if (req[j]) begin
        k = PW'(j);
        any = 1'b1;
      end
    end
    gnt = (any && rst) ? N_CH'(1) << k : '0;
    hist_d = {hist_q[k][PAT_W-2:0], data[k]};
    fill_d = (fill_q[k] == FW'(PAT_W)) ? fill_q[k] : fill_q[k] + 1'b1;
    hit = any && !cfg_we && (fill_d == FW'(PAT_W)) && (hist_d == pattern_q);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pattern_q <= RST_PATTERN;
      ptr_q <= '0;
      flag_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      flag_q <= hit ? N_CH'(1) << k : '0;
      if (any) ptr_q <= (k == PW'(N_CH - 1)) ? '0 : k + 1'b1;
      if (cfg_we) begin
        pattern_q <= cfg_pattern;
        for (int i = 0; i < N_CH; i++) begin
          hist_q[i] <= '0;
          fill_q[i] <= '0;
        end
      end else if (any) begin
        hist_q[k] <= hist_d;
        fill_q[k] <= fill_d;
      end
      for (int i = 0; i < N_CH; i++)
        if (cnt_clr) cnt_q[i] <= '0;
        else if (hit && PW'(i) == k && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  assign flag = flag_q;
  genvar i;
  for (i = 0; i < N_CH; i++) begin : g_cnt
    assign match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
endmodule

// File: tb/tb_seq_match_sched.sv
// tb_seq_match_sched: randomized and directed scoreboard bench against a sliding-window reference model
module tb_seq_match_sched;
  localparam int N = 4, P = 4, CW = 2;
  logic clk = 0, rst = 0, cfg_we = 0, cnt_clr = 0;
  logic [P-1:0] cfg_pattern = '0;
  logic [N-1:0] req = '0, data = '0, gnt, flag;
  logic [N*CW-1:0] match_cnt;
  typedef struct packed {logic [N-1:0] f; logic [N*CW-1:0] c;} exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0;
  logic [P-1:0] m_pat;
  bit m_strm[N][$];
  int m_cnt[N];
  int m_ptr, last_k;
  logic [N-1:0] pend = '0, pdat = '0;
  always #5 clk = ~clk;
  seq_match_sched #(.N_CH(N), .PAT_W(P), .CNT_W(CW), .RST_PATTERN(4'b1011)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
    .req(req), .data(data), .gnt(gnt), .flag(flag), .match_cnt(match_cnt)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_pat = 4'b1011;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_strm[i].delete();
      m_cnt[i] = 0;
    end
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic we,
                      input logic [P-1:0] cp, input logic clr);
    int k;
    logic h;
    logic [P-1:0] w;
    exp_t e;
    @(negedge clk);
    req = r; data = d; cfg_we = we; cfg_pattern = cp; cnt_clr = clr;
    #1;
    k = -1;
    for (int i = 0; i < N; i++) if (k < 0 && r[(m_ptr + i) % N]) k = (m_ptr + i) % N;
    check("gnt", gnt, (k >= 0) ? N'(1) << k : '0);
    h = 0;
    w = '0;
    if (k >= 0) begin
      m_ptr = (k + 1) % N;
      if (!we) begin
        m_strm[k].push_back(d[k]);
        if (m_strm[k].size() > P) void'(m_strm[k].pop_front());
        if (m_strm[k].size() == P) begin
          for (int i = 0; i < P; i++) w[P-1-i] = m_strm[k][i];
          h = (w == m_pat);
        end
      end
    end
    if (we) begin
      m_pat = cp;
      for (int i = 0; i < N; i++) m_strm[i].delete();
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (clr) m_cnt[i] = 0;
      else if (h && i == k && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      e.c[i*CW +: CW] = CW'(m_cnt[i]);
    end
    e.f = h ? N'(1) << k : '0;
    sb.push_back(e);
    last_k = k;
  endtask
  task automatic send(input int ch, input logic b);
    step(N'(1) << ch, N'(b) << ch, 1'b0, '0, 1'b0);
  endtask
  task automatic send_bits(input int ch, input string s);
    for (int i = 0; i < s.len(); i++) send(ch, s[i] == "1");
  endtask
  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_gnt", gnt, '0);
    check("rst_flag", flag, '0);
    check("rst_cnt", match_cnt, '0);
    m_reset();
    pend = '0;
    repeat (cyc) @(negedge clk);
    req = '0; cfg_we = 0; cnt_clr = 0;
    rst = 1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("flag", flag, e.f);
        check("match_cnt", match_cnt, e.c);
      end
    end
  end
  initial begin
    logic [P-1:0] cp;
    m_reset();
    req = 4'b0101;
    do_reset(2);
    send_bits(0, "1011011");
    step('0, '0, 0, '0, 0);
    repeat (8) step(4'hF, N'($urandom), 0, '0, 0);
    step(4'b1010, N'($urandom), 0, '0, 0);
    step(4'b1000, N'($urandom), 0, '0, 0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      send(0, i != 1);
      send(1, i != 1);
    end
    step('0, '0, 0, '0, 0);
    do_reset(1);
    send_bits(0, "101");
    step(4'b0001, 4'b0001, 1, 4'b0110, 0);
    send_bits(0, "0110");
    step('0, '0, 0, '0, 0);
    do_reset(1);
    send_bits(2, "1011011011011");
    send_bits(2, "01");
    step(4'b0100, 4'b0100, 0, '0, 1);
    step('0, '0, 0, '0, 0);
    do_reset(1);
    send_bits(0, "101");
    do_reset(1);
    send_bits(0, "1");
    send_bits(0, "011");
    send_bits(0, "1011");
    step('0, '0, 0, '0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1);
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pdat[i] = $urandom_range(0, 1) == 1;
        end
      cp = ($urandom_range(0, 2) == 0) ? P'($urandom) : ($urandom_range(0, 1) == 1 ? 4'b0110 : 4'b1011);
      step(pend, (pdat & pend) | (N'($urandom) & ~pend), $urandom_range(0, 99) == 0, cp,
           $urandom_range(0, 199) == 0);
      if (last_k >= 0) pend[last_k] = 0;
    end
    step('0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
